// File: rtl/mdu_pkg.sv
// Shared MDU definitions: divider FSM states and iteration-count helpers.
package mdu_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } divstate_t;

  // Cycles needed for one division: word ops only walk 32 dividend bits.
  function automatic int unsigned div_iters(input int unsigned xlen,
                                            input int unsigned divcopies,
                                            input logic w64);
    return w64 ? (32 / divcopies) : (xlen / divcopies);
  endfunction

  function automatic int unsigned div_cnt_width(input int unsigned xlen,
                                                input int unsigned divcopies);
    return $clog2(xlen / divcopies + 1);
  endfunction

endpackage

// File: rtl/div_step_chain.sv
// Combinational chain of DIVCOPIES divide steps evaluated in a single cycle.
module div_step_chain #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned DIVCOPIES = 4
) (
  input  logic [XLEN-1:0] w,
  input  logic [XLEN-1:0] xq,
  input  logic [XLEN-1:0] dabsb,
  output logic [XLEN-1:0] wn,
  output logic [XLEN-1:0] xqn
);

  logic [XLEN-1:0] w_s  [DIVCOPIES+1];
  logic [XLEN-1:0] xq_s [DIVCOPIES+1];

  assign w_s[0]  = w;
  assign xq_s[0] = xq;

  for (genvar i = 0; i < DIVCOPIES; i++) begin : g_step
    divstep #(
      .XLEN(XLEN)
    ) u_divstep (
      .w    (w_s[i]),
      .xq   (xq_s[i]),
      .dabsb(dabsb),
      .wn   (w_s[i+1]),
      .xqn  (xq_s[i+1])
    );
  end

  assign wn  = w_s[DIVCOPIES];
  assign xqn = xq_s[DIVCOPIES];

endmodule

// File: rtl/divstep.sv
// One restoring radix-2 step: shift {w, xq} left, trial-subtract the divisor, keep on no borrow.
module divstep #(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] w,
  input  logic [XLEN-1:0] xq,
  input  logic [XLEN-1:0] dabsb,
  output logic [XLEN-1:0] wn,
  output logic [XLEN-1:0] xqn
);

  logic [XLEN:0] wshift;
  logic [XLEN:0] diff;
  logic          qbit;

  // One extra bit so a divisor of 2^(XLEN-1) cannot overflow the trial subtract.
  assign wshift = {w, xq[XLEN-1]};
  assign diff   = wshift + {1'b1, dabsb};
  assign qbit   = ~diff[XLEN];
  assign wn     = qbit ? diff[XLEN-1:0] : wshift[XLEN-1:0];
  assign xqn    = {xq[XLEN-2:0], qbit};

endmodule

// File: rtl/div_seq_ctrl.sv
// Iterative restoring divider controller: operand prep, iteration FSM, special cases, sign fix-up.
import mdu_pkg::*;

module div_seq_ctrl #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned DIVCOPIES = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            Start,
  input  logic            Flush,
  input  logic            Signed,
  input  logic            W64,
  input  logic            Rem,
  input  logic [XLEN-1:0] X,
  input  logic [XLEN-1:0] D,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] Result
);

  localparam int unsigned CntW = div_cnt_width(XLEN, DIVCOPIES);

  divstate_t       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] w_q, w_d;
  logic [XLEN-1:0] xq_q, xq_d;
  logic [XLEN-1:0] dabsb_q, dabsb_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;
  logic            rem_q, rem_d;
  logic            w64_q, w64_d;

  logic            w64_eff;
  logic [XLEN-1:0] xe, de, xabs, dabs, xq_init;
  logic [XLEN-1:0] w_nxt, xq_nxt;
  logic [CntW-1:0] cnt_last;

  assign w64_eff = (XLEN == 64) && W64;

  always_comb begin
    if (w64_eff) begin
      xe = Signed ? XLEN'($signed(X[31:0])) : XLEN'(X[31:0]);
      de = Signed ? XLEN'($signed(D[31:0])) : XLEN'(D[31:0]);
    end else begin
      xe = X;
      de = D;
    end
    xabs    = (Signed && xe[XLEN-1]) ? -xe : xe;
    dabs    = (Signed && de[XLEN-1]) ? -de : de;
    // Word ops park the 32-bit dividend in the top half so the MSB-first shift sees it first.
    xq_init = w64_eff ? (xabs << 32) : xabs;
  end

  assign cnt_last = CntW'(div_iters(XLEN, DIVCOPIES, w64_q) - 1);

  div_step_chain #(
    .XLEN     (XLEN),
    .DIVCOPIES(DIVCOPIES)
  ) u_chain (
    .w    (w_q),
    .xq   (xq_q),
    .dabsb(dabsb_q),
    .wn   (w_nxt),
    .xqn  (xq_nxt)
  );

  function automatic logic [XLEN-1:0] fixup(input logic rem, input logic negq,
                                            input logic negr, input logic w64,
                                            input logic [XLEN-1:0] r,
                                            input logic [XLEN-1:0] q);
    logic [XLEN-1:0] v;
    v = rem ? (negr ? -r : r) : (negq ? -q : q);
    if (w64) v = XLEN'($signed(v[31:0]));
    return v;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    w_d      = w_q;
    xq_d     = xq_q;
    dabsb_d  = dabsb_q;
    result_d = result_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    rem_d    = rem_q;
    w64_d    = w64_q;
    unique case (state_q)
      StIdle: begin
        if (!Flush && Start) begin
          negq_d = Signed & (xe[XLEN-1] ^ de[XLEN-1]);
          negr_d = Signed & xe[XLEN-1];
          rem_d  = Rem;
          w64_d  = w64_eff;
          if (de == '0) begin
            result_d = fixup(Rem, 1'b0, 1'b0, w64_eff, xe, '1);
            state_d  = StDone;
          end else begin
            w_d     = '0;
            xq_d    = xq_init;
            dabsb_d = -dabs;
            cnt_d   = '0;
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        if (Flush) begin
          state_d = StIdle;
        end else begin
          w_d   = w_nxt;
          xq_d  = xq_nxt;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == cnt_last) begin
            result_d = fixup(rem_q, negq_q, negr_q, w64_q, w_nxt, xq_nxt);
            state_d  = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      w_q      <= '0;
      xq_q     <= '0;
      dabsb_q  <= '0;
      result_q <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      rem_q    <= 1'b0;
      w64_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      w_q      <= w_d;
      xq_q     <= xq_d;
      dabsb_q  <= dabsb_d;
      result_q <= result_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      rem_q    <= rem_d;
      w64_q    <= w64_d;
    end
  end

  assign Busy   = (state_q == StBusy);
  assign Done   = (state_q == StDone);
  assign Result = result_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl (XLEN=64, DIVCOPIES=4) with hand-computed results.
module tb_div_seq_ctrl;

  logic        clk;
  logic        resetn;
  logic        Start;
  logic        Flush;
  logic        Signed;
  logic        W64;
  logic        Rem;
  logic [63:0] X;
  logic [63:0] D;
  logic        Busy;
  logic        Done;
  logic [63:0] Result;

  int checks = 0;
  int errors = 0;

  div_seq_ctrl #(
    .XLEN     (64),
    .DIVCOPIES(4)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .Start (Start),
    .Flush (Flush),
    .Signed(Signed),
    .W64   (W64),
    .Rem   (Rem),
    .X     (X),
    .D     (D),
    .Busy  (Busy),
    .Done  (Done),
    .Result(Result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, then measure Busy cycles and the edge on which Done appears.
  task automatic do_op(input string tag, input logic s, input logic w, input logic r,
                       input logic [63:0] x, input logic [63:0] d,
                       input logic [63:0] exp, input int nbusy);
    int   busy_cnt;
    int   edges;
    logic seen;
    @(negedge clk);
    Signed = s; W64 = w; Rem = r; X = x; D = d; Start = 1'b1;
    tick();
    Start    = 1'b0;
    busy_cnt = 0;
    edges    = 0;
    seen     = 1'b0;
    while (!seen && edges < 200) begin
      if (Done) begin
        seen = 1'b1;
      end else begin
        if (Busy) busy_cnt++;
        tick();
        edges++;
      end
    end
    check({tag, "_done"}, 64'(seen), 64'd1);
    check({tag, "_busy"}, 64'(busy_cnt), 64'(nbusy));
    check({tag, "_lat"}, 64'(edges), 64'(nbusy));
    check({tag, "_res"}, Result, exp);
    tick();
    check({tag, "_pulse"}, {62'd0, Busy, Done}, 64'd0);
    check({tag, "_hold"}, Result, exp);
  endtask

  initial begin
    resetn = 1'b0; Start = 1'b0; Flush = 1'b0; Signed = 1'b0; W64 = 1'b0; Rem = 1'b0;
    X = '0; D = '0;
    tick();
    tick();
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_done", 64'(Done), 64'd0);
    check("rst_res", Result, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    do_op("udiv", 1'b0, 1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 16);
    do_op("urem", 1'b0, 1'b0, 1'b1, 64'd100, 64'd7, 64'd2, 16);
    do_op("sdiv", 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,
          64'hFFFF_FFFF_FFFF_FFF2, 16);
    do_op("srem", 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,
          64'hFFFF_FFFF_FFFF_FFFE, 16);
    do_op("dz_q", 1'b1, 1'b0, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    do_op("dz_r", 1'b1, 1'b0, 1'b1, 64'h1234, 64'd0, 64'h1234, 0);
    do_op("ovf_q", 1'b1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          64'h8000_0000_0000_0000, 16);
    do_op("ovf_r", 1'b1, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          64'd0, 16);
    do_op("divuw", 1'b0, 1'b1, 1'b0, 64'hAAAA_AAAA_FFFF_FFFE, 64'd2,
          64'h0000_0000_7FFF_FFFF, 8);
    do_op("divuw_sx", 1'b0, 1'b1, 1'b0, 64'h1234_5678_8000_0001, 64'hFFFF_0000_0000_0001,
          64'hFFFF_FFFF_8000_0001, 8);
    do_op("remuw", 1'b0, 1'b1, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h10, 64'hF, 8);
    do_op("divw", 1'b1, 1'b1, 1'b0, 64'h0000_0000_FFFF_FF9C, 64'h7,
          64'hFFFF_FFFF_FFFF_FFF2, 8);
    do_op("remuw_dz", 1'b0, 1'b1, 1'b1, 64'h5555_5555_9000_0000, 64'hFFFF_FFFF_0000_0000,
          64'hFFFF_FFFF_9000_0000, 0);

    // Abort on the fifth Busy cycle; previous Result must survive and no Done may appear.
    @(negedge clk);
    Signed = 1'b0; W64 = 1'b0; Rem = 1'b0; X = 64'd100; D = 64'd7; Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (4) tick();
    check("fl_busy5", 64'(Busy), 64'd1);
    @(negedge clk);
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    check("fl_idle", {62'd0, Busy, Done}, 64'd0);
    check("fl_res", Result, 64'hFFFF_FFFF_9000_0000);
    do_op("post_fl", 1'b0, 1'b0, 1'b0, 64'd9, 64'd3, 64'd3, 16);

    // Reset mid-operation clears every output.
    @(negedge clk);
    X = 64'd1000; D = 64'd3; Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    resetn = 1'b0;
    tick();
    check("mrst_flags", {62'd0, Busy, Done}, 64'd0);
    check("mrst_res", Result, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Flush beats Start in IDLE, even for a divide-by-zero request.
    @(negedge clk);
    X = 64'd50; D = 64'd0; Start = 1'b1; Flush = 1'b1;
    tick();
    Start = 1'b0; Flush = 1'b0;
    check("sf_idle0", {62'd0, Busy, Done}, 64'd0);
    tick();
    check("sf_idle1", {62'd0, Busy, Done}, 64'd0);
    check("sf_res", Result, 64'd0);

    do_op("after_all", 1'b0, 1'b0, 1'b1, 64'd1000, 64'd3, 64'd1, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Iterative radix-2 restoring integer divider controller for the MDU.
- Owns the residual and dividend/quotient registers, operand preparation, iteration counting, special-case handling and final sign fix-up.
- Each cycle it drives a combinational chain of DIVCOPIES `divstep` instances.
- Serves RV32/RV64 DIV/DIVU/REM/REMU and their W forms, and reports Busy/Done to the pipeline stall logic.

Parameters:
- XLEN, 64, datapath width (32 or 64).
- DIVCOPIES, 4, divstep instances chained per cycle; must divide 32.

Ports:
- clk  input  1  clock
- resetn  input  1  synchronous active-low reset
- Start  input  1  request a new division; accepted only in IDLE
- Flush  input  1  abort current operation
- Signed  input  1  signed operation
- W64  input  1  32-bit word operation (ignored when XLEN=32)
- Rem  input  1  1 = return remainder, 0 = return quotient
- X  input  XLEN  dividend
- D  input  XLEN  divisor
- Busy  output  1  operation in progress (BUSY state)
- Done  output  1  single-cycle pulse; Result valid
- Result  output  XLEN  quotient or remainder

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous, active-low on resetn.
  - On resetn=0 at a clk edge: state=IDLE, Busy=0, Done=0, Result=0, counter=0, W=0, XQ=0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Flush=1: remain in IDLE; Flush wins over a simultaneous Start.
  - Start=1 and D (effective) = 0: capture the special result, go to DONE.
  - Start=1 otherwise: load the operand registers, counter=0, go to BUSY.
- Operand preparation at Start:
  - W64=1: Xe/De are bits [31:0] of X/D, sign-extended if Signed, else zero-extended.
  - W64=0: Xe=X, De=D.
  - XAbs = (Signed & Xe msb) ? -Xe : Xe; DAbs likewise.
  - DAbsB = two's-complement negative of DAbs, XLEN bits.
  - W=0.
  - XQ=XAbs, or {XAbs[31:0], 32'b0} when W64=1 and XLEN=64.
  - Latch NegQ = Signed & (Xe msb ^ De msb), NegR = Signed & Xe msb, Rem, W64.
- BUSY:
  - Each cycle, W/XQ <= output of the DIVCOPIES-long divstep chain; counter++.
  - Iterations N = XLEN/DIVCOPIES, or 32/DIVCOPIES when W64 is latched.
  - On the cycle where counter = N-1 the final step is registered; go to DONE.
  - Flush=1 in BUSY: go to IDLE next edge, Done never asserted, Result unchanged.
- DONE:
  - Done=1 for exactly one cycle; Result is registered on entry to DONE.
  - Next state is IDLE unconditionally.
  - Start is ignored in DONE; Flush in DONE only suppresses nothing (result already valid).
- Result selection:
  - Quotient Q = final XQ; remainder R = final W.
  - Result = Rem ? (NegR ? -R : R) : (NegQ ? -Q : Q).
  - For W64, the 32-bit result is sign-extended from bit 31, including unsigned W ops.
- Divide by zero (effective De=0):
  - Quotient = all ones; remainder = Xe.
  - W64 sign extension rules apply.
  - Latency is Start -> Done in 1 cycle.
- Overflow (most-negative / -1, signed): no special path; the algorithm yields Q=X, R=0 naturally.
- Latency:
  - Normal operation: Start edge -> Done asserted N+1 cycles later.
  - Busy=1 for exactly N cycles.
- Result holds its value from DONE until the next Start is accepted.
- Start while Busy or Done is dropped; the requester must hold Start until it is accepted.

Decomposition:
- Shared package `mdu_pkg`:
  - state enum type divstate_t {IDLE, BUSY, DONE}.
  - localparam function for iteration count.
  - counter width $clog2(XLEN/DIVCOPIES+1).
- Sub-module `div_step_chain` (XLEN, DIVCOPIES): generate loop of divstep instances; pure combinational; W/XQ in, W/XQ out.
- FSM, counter, operand prep and result fix-up stay in div_seq_ctrl.

Test Plan:
1. XLEN=64, DIVCOPIES=4, Signed=0, Rem=0, X=100, D=7, Start 1 cycle -> Busy high 16 cycles, Done pulses on cycle 17, Result=14; Rem=1 gives Result=2.
2. Signed=1, X=-100, D=7 -> quotient Result=-14 (0xFFFF_FFFF_FFFF_FFF2); remainder Result=-2.
3. Divide by zero, Signed=1, X=0x1234, D=0 -> Done the cycle after Start, quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=0x1234.
4. Overflow, Signed=1, X=0x8000_0000_0000_0000, D=-1 -> quotient=0x8000_0000_0000_0000, remainder=0.
5. W64=1, Signed=0, X=0xAAAA_AAAA_FFFF_FFFE, D=0x2 -> Busy 8 cycles, quotient=0x0000_0000_7FFF_FFFF.
6. Flush on BUSY cycle 5, then Start (X=9, D=3) the following IDLE cycle -> no Done for the aborted op, Result=3 for the new op. Also check resetn=0 mid-BUSY -> all outputs 0 the next cycle, and Start+Flush in IDLE -> stays IDLE.
